// File: rtl/result_collector_pkg.sv
// Shared types, encodings and helpers for the Mandelbrot result collector.
// Engines hand {x, y, itr} words to the collector, which turns them into frame-buffer writes.
package result_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] COLOR_MODE_RAW       = 2'd0;
  localparam logic [1:0] COLOR_MODE_SET_BLACK = 2'd1;
  localparam logic [1:0] COLOR_MODE_INVERT    = 2'd2;
  localparam logic [1:0] COLOR_MODE_RAW_ALT   = 2'd3;

  localparam int DEF_NUM_PROC = 12;
  localparam int DEF_X_W      = 10;
  localparam int DEF_Y_W      = 9;
  localparam int DEF_ITR_W    = 8;
  localparam int DEF_H_RES    = 640;
  localparam int DEF_V_RES    = 480;
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_ITR  = 255;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Engine index reached by stepping 'offset' places past 'last', wrapping at n.
  function automatic int rr_index(input int last, input int offset, input int n);
    int j;
    j = last + offset;
    return (j >= n) ? (j - n) : j;
  endfunction

endpackage

// File: rtl/result_collector_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick of the first requester after the last grant.
// The last-grant pointer advances only when the owner commits the pick with advance_i.
module result_collector_rr_arbiter
  import result_collector_pkg::*;
#(
  parameter int NUM_PROC = DEF_NUM_PROC
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NUM_PROC-1:0] req_i,
  input  logic                advance_i,
  output logic [NUM_PROC-1:0] grant_o,
  output logic                valid_o
);

  localparam int IDX_W = idx_width(NUM_PROC);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] last_d;
  logic [IDX_W-1:0] pick_s;

  // Scan from the farthest candidate back to the nearest so the nearest requester wins.
  always_comb begin
    pick_s = last_q;
    for (int off = NUM_PROC; off >= 1; off--) begin
      pick_s = req_i[IDX_W'(rr_index(int'(last_q), off, NUM_PROC))]
             ? IDX_W'(rr_index(int'(last_q), off, NUM_PROC))
             : pick_s;
    end
    valid_o = |req_i;
    grant_o = valid_o ? (NUM_PROC'(1) << pick_s) : '0;
    last_d  = (advance_i && valid_o) ? pick_s : last_q;
  end

  // Pointer starts at the top engine so engine 0 is first in line after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= IDX_W'(NUM_PROC - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects Mandelbrot engine results through a round-robin handshake and converts each
// {x, y, itr} word into a frame-buffer write, tracking pixels per frame and bad coordinates.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int NUM_PROC = DEF_NUM_PROC,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int ITR_W    = DEF_ITR_W,
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_ITR  = DEF_MAX_ITR
) (
  input  logic                     clk_iCLK,
  input  logic                     reset,
  input  logic [NUM_PROC-1:0]      engine_req,
  output logic [NUM_PROC-1:0]      req_ack,
  input  logic [X_W+Y_W+ITR_W-1:0] in_word,
  input  logic [1:0]               color_mode,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W-1:0]        pixel_count,
  output logic                     frame_done,
  output logic                     coord_err
);

  localparam int WORD_W = X_W + Y_W + ITR_W;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_RES * V_RES - 1);

  state_e              state_q, state_d;
  logic [NUM_PROC-1:0] req_ack_q, ack_d;
  logic [NUM_PROC-1:0] arb_grant_s;
  logic                arb_valid_s;
  logic                advance_s;

  logic                cap_valid_q, cap_valid_d;
  logic [WORD_W-1:0]   cap_word_q, cap_word_d;
  logic [1:0]          cap_mode_q, cap_mode_d;

  logic [X_W-1:0]      x_s;
  logic [Y_W-1:0]      y_s;
  logic [ITR_W-1:0]    itr_s;
  logic [DATA_W-1:0]   itr_lo_s;
  logic                itr_max_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [DATA_W-1:0]   data_s;

  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   pixel_count_q, pixel_count_d;
  logic                frame_done_q, frame_done_d;
  logic                coord_err_q, coord_err_d;

  result_collector_rr_arbiter #(
    .NUM_PROC (NUM_PROC)
  ) u_arb (
    .clk_i     (clk_iCLK),
    .reset_i   (reset),
    .req_i     (engine_req),
    .advance_i (advance_s),
    .grant_o   (arb_grant_s),
    .valid_o   (arb_valid_s)
  );

  // Handshake FSM; requests are looked at only in IDLE so an acked engine has HOLD to drop its line.
  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d   = ST_ACK;
          ack_d     = arb_grant_s;
          advance_s = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the shared bus at the end of the ACK cycle, while the granted engine drives it.
  always_comb begin
    cap_valid_d = (state_q == ST_ACK);
    cap_word_d  = cap_valid_d ? in_word : cap_word_q;
    cap_mode_d  = cap_valid_d ? color_mode : cap_mode_q;
  end

  // S1: address, range check and pixel data mapping from the captured word.
  always_comb begin
    x_s        = cap_word_q[WORD_W-1 -: X_W];
    y_s        = cap_word_q[ITR_W +: Y_W];
    itr_s      = cap_word_q[ITR_W-1:0];
    itr_lo_s   = itr_s[DATA_W-1:0];
    itr_max_s  = (32'(itr_s) == MAX_ITR);
    in_range_s = (32'(x_s) < H_RES) && (32'(y_s) < V_RES);
    addr_s     = ADDR_W'(x_s) + ADDR_W'(y_s) * ADDR_W'(H_RES);
    case (cap_mode_q)
      COLOR_MODE_RAW:       data_s = itr_lo_s;
      COLOR_MODE_SET_BLACK: data_s = itr_max_s ? '0 : itr_lo_s;
      COLOR_MODE_INVERT:    data_s = ~itr_lo_s;
      COLOR_MODE_RAW_ALT:   data_s = itr_lo_s;
      default:              data_s = itr_lo_s;
    endcase
  end

  // S2 next state: write strobe, frame counter with wrap, sticky coordinate error.
  always_comb begin
    wr_en_d       = cap_valid_q && in_range_s;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    pixel_count_d = pixel_count_q;
    frame_done_d  = 1'b0;
    coord_err_d   = coord_err_q | (cap_valid_q & ~in_range_s);
    if (wr_en_d) begin
      wr_addr_d     = addr_s;
      wr_data_d     = data_s;
      frame_done_d  = (pixel_count_q == LAST_PIX);
      pixel_count_d = frame_done_d ? '0 : pixel_count_q + 1'b1;
    end else begin
      frame_done_d  = 1'b0;
    end
  end

  // State and pipeline registers; reset discards any capture or write in flight.
  always_ff @(posedge clk_iCLK) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ack_q     <= '0;
      cap_valid_q   <= 1'b0;
      cap_word_q    <= '0;
      cap_mode_q    <= 2'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      pixel_count_q <= '0;
      frame_done_q  <= 1'b0;
      coord_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ack_q     <= ack_d;
      cap_valid_q   <= cap_valid_d;
      cap_word_q    <= cap_word_d;
      cap_mode_q    <= cap_mode_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      pixel_count_q <= pixel_count_d;
      frame_done_q  <= frame_done_d;
      coord_err_q   <= coord_err_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign pixel_count = pixel_count_q;
  assign frame_done  = frame_done_q;
  assign coord_err   = coord_err_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a write scoreboard; uses a small 16x12 frame
// so a complete frame fits in a short run.
module tb_result_collector;

  localparam int NP    = 12;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int IW    = 8;
  localparam int HR    = 16;
  localparam int VR    = 12;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int MI    = 255;
  localparam int TOTAL = HR * VR;
  localparam int WW    = XW + YW + IW;

  typedef struct {
    int addr;
    int data;
    int fd;
    int pc;
  } exp_t;

  logic          clk_iCLK = 1'b0;
  logic          reset;
  logic [NP-1:0] engine_req;
  logic [NP-1:0] req_ack;
  logic [WW-1:0] in_word;
  logic [1:0]    color_mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] pixel_count;
  logic          frame_done;
  logic          coord_err;

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   ack_cyc   = 0;
  int   fd_count  = 0;
  int   model_pc  = 0;
  int   t0;
  int   fd_before;
  int   n_left;
  exp_t sb[$];
  exp_t mon_e;

  result_collector #(
    .NUM_PROC (NP), .X_W (XW), .Y_W (YW), .ITR_W (IW), .H_RES (HR), .V_RES (VR),
    .ADDR_W (AW), .DATA_W (DW), .MAX_ITR (MI)
  ) dut (
    .clk_iCLK    (clk_iCLK),
    .reset       (reset),
    .engine_req  (engine_req),
    .req_ack     (req_ack),
    .in_word     (in_word),
    .color_mode  (color_mode),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .coord_err   (coord_err)
  );

  always #5 clk_iCLK = ~clk_iCLK;

  always @(posedge clk_iCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_data(input logic [1:0] mode, input int itr);
    int v;
    case (mode)
      2'd1:    v = (itr == MI) ? 0 : itr;
      2'd2:    v = ~itr;
      default: v = itr;
    endcase
    return v & ((1 << DW) - 1);
  endfunction

  // Wait for the grant, drive the engine's word during its ACK cycle, and log the expected write.
  task automatic serve(input int idx, input int x, input int y, input int itr, input logic [1:0] mode);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk_iCLK);
      n++;
    end while (req_ack == '0 && n < 12);
    if (req_ack == '0) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else begin
      check("ack_onehot", req_ack, 32'd1 << idx);
      ack_cyc          = cyc;
      in_word          = {XW'(x), YW'(y), IW'(itr)};
      color_mode       = mode;
      engine_req[idx]  = 1'b0;
      if (x < HR && y < VR) begin
        e.addr   = x + y * HR;
        e.data   = exp_data(mode, itr);
        e.fd     = (model_pc == TOTAL - 1) ? 1 : 0;
        model_pc = (e.fd == 1) ? 0 : model_pc + 1;
        e.pc     = model_pc;
        sb.push_back(e);
      end
    end
  endtask

  always @(negedge clk_iCLK) begin
    if (wr_en) begin
      if (frame_done) fd_count <= fd_count + 1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", wr_data, mon_e.data);
        check("frame_done", frame_done, mon_e.fd);
        check("pixel_count", pixel_count, mon_e.pc);
      end else begin
        check("unexpected_wr", {31'd0, wr_en}, 32'd0);
      end
    end else begin
      check("fd_without_wr", frame_done, 32'd0);
    end
  end

  initial begin
    reset      = 1'b1;
    engine_req = '0;
    in_word    = '0;
    color_mode = 2'd0;

    // Reset held with no requests.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_iCLK);
      check("rst_req_ack", req_ack, 32'd0);
      check("rst_wr_en", wr_en, 32'd0);
      check("rst_pixel_count", pixel_count, 32'd0);
      check("rst_coord_err", coord_err, 32'd0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_iCLK);
    check("idle_req_ack", req_ack, 32'd0);

    // Single engine 3, exact latency.
    engine_req[3] = 1'b1;
    serve(3, 5, 2, 17, 2'd0);
    @(negedge clk_iCLK);
    check("ack_one_cycle", req_ack, 32'd0);
    check("wr_not_yet", wr_en, 32'd0);
    @(negedge clk_iCLK);
    check("t2_wr_en", wr_en, 32'd1);
    check("t2_wr_addr", wr_addr, 32'd5 + 32'd2 * HR);
    check("t2_wr_data", wr_data, 32'd17);

    // Round-robin among engines 0..2, twice.
    repeat (3) @(negedge clk_iCLK);
    for (int r = 0; r < 2; r++) begin
      engine_req[2:0] = 3'b111;
      serve(0, 1 + r, 1, 3, 2'd0);
      t0 = ack_cyc;
      serve(1, 2 + r, 1, 4, 2'd0);
      check("rr_gap_01", ack_cyc - t0, 32'd3);
      t0 = ack_cyc;
      serve(2, 3 + r, 1, 5, 2'd0);
      check("rr_gap_12", ack_cyc - t0, 32'd3);
      repeat (4) @(negedge clk_iCLK);
    end

    // Color modes.
    engine_req[6] = 1'b1;
    serve(6, 1, 3, 255, 2'd1);
    engine_req[6] = 1'b1;
    serve(6, 2, 3, 8'h0F, 2'd2);
    engine_req[6] = 1'b1;
    serve(6, 3, 3, 254, 2'd1);
    engine_req[6] = 1'b1;
    serve(6, 4, 3, 8'hA5, 2'd3);
    repeat (4) @(negedge clk_iCLK);

    // Out-of-range coordinates.
    engine_req[8] = 1'b1;
    serve(8, HR, 0, 9, 2'd0);
    repeat (4) @(negedge clk_iCLK);
    check("xerr_coord_err", coord_err, 32'd1);
    check("xerr_pixel_count", pixel_count, model_pc);
    engine_req[8] = 1'b1;
    serve(8, 0, VR, 9, 2'd0);
    repeat (4) @(negedge clk_iCLK);
    check("yerr_coord_err", coord_err, 32'd1);
    check("yerr_pixel_count", pixel_count, model_pc);

    // Fill the rest of the frame.
    fd_before = fd_count;
    n_left    = TOTAL - model_pc;
    for (int k = 0; k < n_left; k++) begin
      engine_req[9] = 1'b1;
      serve(9, k % HR, (k / HR) % VR, k % 256, 2'd0);
    end
    repeat (4) @(negedge clk_iCLK);
    check("frame_wrap_pc", pixel_count, 32'd0);
    check("frame_done_pulses", fd_count - fd_before, 32'd1);
    check("coord_err_sticky", coord_err, 32'd1);

    // Reset during ACK.
    engine_req[7] = 1'b1;
    @(negedge clk_iCLK);
    check("pre_rst_ack", req_ack, 32'd1 << 7);
    in_word       = {XW'(1), YW'(1), IW'(33)};
    reset         = 1'b1;
    engine_req    = '0;
    @(negedge clk_iCLK);
    check("mid_rst_req_ack", req_ack, 32'd0);
    check("mid_rst_wr_en", wr_en, 32'd0);
    check("mid_rst_pixel_count", pixel_count, 32'd0);
    reset    = 1'b0;
    model_pc = 0;
    repeat (5) @(negedge clk_iCLK);
    check("post_rst_coord_err", coord_err, 32'd0);
    check("post_rst_pixel_count", pixel_count, 32'd0);

    // Pointer restarts at engine 0 after reset.
    engine_req[0] = 1'b1;
    engine_req[5] = 1'b1;
    serve(0, 6, 6, 40, 2'd0);
    serve(5, 7, 6, 41, 2'd2);
    repeat (5) @(negedge clk_iCLK);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
